mux_bus_master: RTL

MUX_BUS_MASTER -- requirements
Module: mux_bus_master

---
 rtl/mux_bus_master.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mux_bus_master.sv
// rtl/mux_bus_master.sv - multiplexed address/data bus master with ALE/RD/WR strobes
module mux_bus_master #(
  parameter int unsigned ALE_CYC  = 2,
  parameter int unsigned STB_CYC  = 3,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       ale,
  output logic       rd,
  output logic       wr
);

  // Each phase counter is loaded with (length - 1) and the phase ends when it reaches 0.
  localparam logic [3:0] ALE_LOAD  = 4'(ALE_CYC - 1);
  localparam logic [3:0] STB_LOAD  = 4'(STB_CYC - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_TURN   = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       is_write;
  logic [7:0] wdata_q;

  // Bus cycle sequencer; every bus and handshake output is a flop updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      is_write  <= 1'b0;
      wdata_q   <= 8'h00;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      ad_out    <= 8'h00;
      ad_oe     <= 1'b0;
      ale       <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
    end else begin
      // The completion pulse lasts only the first IDLE cycle.
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            // Capture the whole request; later input changes have no effect.
            state     <= ST_ADDR;
            cnt       <= ALE_LOAD;
            is_write  <= req_write;
            wdata_q   <= req_wdata;
            ad_out    <= req_addr;
            ad_oe     <= 1'b1;
            ale       <= 1'b1;
            req_ready <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (cnt == 4'd0) begin
            // Writes start driving data right away; reads release the bus for the target.
            state  <= ST_TURN;
            cnt    <= 4'd0;
            ale    <= 1'b0;
            ad_oe  <= is_write;
            ad_out <= is_write ? wdata_q : 8'h00;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_TURN: begin
          state <= ST_STROBE;
          cnt   <= STB_LOAD;
          wr    <= is_write;
          rd    <= !is_write;
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            // Read data is sampled on the edge that ends the strobe.
            state <= ST_HOLD;
            cnt   <= HOLD_LOAD;
            rd    <= 1'b0;
            wr    <= 1'b0;
            if (!is_write) begin
              rsp_rdata <= ad_in;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd0) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out    <= 8'h00;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= 4'd0;
          req_ready <= 1'b1;
          ad_oe     <= 1'b0;
          ad_out    <= 8'h00;
          ale       <= 1'b0;
          rd        <= 1'b0;
          wr        <= 1'b0;
        end
      endcase
    end
  end

endmodule
